seq_divider16x8: RTL and testbench

- Iterative unsigned divider: divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, producing a WIDTH-bit quotient and a WIDTH-bit remainder.
- It is the inverse of the 8x8 Wallace-tree multiplier: for in-range results, quotient*divisor + remainder == dividend, with the 16-bit value matching the multiplier product format.
- Restoring algorithm, one quotient bit per clock.
- Valid/ready handshakes on both sides so it drops into the same datapaths as the multiplier.

---
 rtl/seq_divider16x8.sv | 155 +++++++++++++++
 tb/tb_seq_divider16x8.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider16x8.sv
// Iterative restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor.
// Produces one quotient bit per clock. Valid/ready handshakes on both sides.
// Divide-by-zero and quotient overflow are detected up front and answered
// in a single cycle.
module seq_divider16x8 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_zero,
  output logic                 ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder R
  logic [WIDTH-1:0] quo_q, quo_d;      // shifting dividend low half / quotient Q
  logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor captured at accept
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] dividend_hi;
  logic [WIDTH-1:0] dividend_lo;

  assign dividend_hi = dividend[2*WIDTH-1:WIDTH];
  assign dividend_lo = dividend[WIDTH-1:0];

  // One restoring step: trial-subtract the divisor from the shifted remainder.
  // R < divisor always holds, so a non-negative difference fits in WIDTH bits.
  always_comb begin
    diff = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    if (!diff[WIDTH]) begin
      rem_step = diff[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_step = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and datapath-load logic; everything holds unless changed.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            state_d     = DONE;
            div_zero_d  = 1'b1;
            ovf_d       = 1'b0;
            quotient_d  = ONES;
            remainder_d = dividend_lo;
          end else if (dividend_hi >= divisor) begin
            // Quotient would need more than WIDTH bits.
            state_d     = DONE;
            div_zero_d  = 1'b0;
            ovf_d       = 1'b1;
            quotient_d  = ONES;
            remainder_d = ONES;
          end else begin
            state_d    = CALC;
            rem_d      = dividend_hi;
            quo_d      = dividend_lo;
            dvs_d      = divisor;
            cnt_d      = '0;
            div_zero_d = 1'b0;
            ovf_d      = 1'b0;
          end
        end
      end
      CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d     = DONE;
          quotient_d  = quo_step;
          remainder_d = rem_step;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_divider16x8.sv
// Self-checking bench for seq_divider16x8 (WIDTH=8 with scoreboard, plus a
// WIDTH=4 instance exercised by a random loop).
module tb_seq_divider16x8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor, quotient, remainder;
  logic        div_zero, ovf;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [7:0]  dividend4;
  logic [3:0]  divisor4, quotient4, remainder4;
  logic        div_zero4, ovf4;

  seq_divider16x8 #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .ovf(ovf)
  );

  seq_divider16x8 #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .dividend(dividend4), .divisor(divisor4), .out_valid(out_valid4),
    .out_ready(out_ready4), .quotient(quotient4), .remainder(remainder4),
    .div_zero(div_zero4), .ovf(ovf4)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_ops    = 0;
  logic [17:0] exp_q[$];
  bit stall_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: {div_zero, ovf, quotient, remainder}
  function automatic logic [17:0] model8(input logic [15:0] dd, input logic [7:0] dv);
    logic [15:0] q, r;
    if (dv == 8'd0) return {2'b10, 8'hFF, dd[7:0]};
    if (dd[15:8] >= dv) return {2'b01, 8'hFF, 8'hFF};
    q = dd / {8'd0, dv};
    r = dd % {8'd0, dv};
    return {2'b00, q[7:0], r[7:0]};
  endfunction

  function automatic logic [9:0] model4(input logic [7:0] dd, input logic [3:0] dv);
    logic [7:0] q, r;
    if (dv == 4'd0) return {2'b10, 4'hF, dd[3:0]};
    if (dd[7:4] >= dv) return {2'b01, 4'hF, 4'hF};
    q = dd / {4'd0, dv};
    r = dd % {4'd0, dv};
    return {2'b00, q[3:0], r[3:0]};
  endfunction

  // Scoreboard: push on accepted request, pop/compare on result handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model8(dividend, divisor));
      if (out_valid && out_ready) begin
        check_eq("result_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check_eq("sb_result", {14'd0, div_zero, ovf, quotient, remainder}, {14'd0, exp_q.pop_front()});
        end
        n_ops++;
        $display("op %0d: q=%02h r=%02h dz=%0b ovf=%0b", n_ops, quotient, remainder, div_zero, ovf);
      end
    end
  end

  // Random consumer stalls.
  always @(posedge clk) begin
    if (stall_en) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [15:0] dd, input logic [7:0] dv);
    bit ok;
    ok = 1'b0;
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("accept", 32'(ok), 32'd1);
  endtask

  // Number of cycles after the accept edge until out_valid is seen (0 = timeout).
  task automatic wait_out(output int lat);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic directed(input logic [15:0] dd, input logic [7:0] dv, input int exp_lat,
                          input logic [17:0] exp, input string tag);
    int lat;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(dd, dv);
    wait_out(lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_res"}, {14'd0, div_zero, ovf, quotient, remainder}, {14'd0, exp});
    @(negedge clk);
    check_eq({tag, "_one_cycle"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit stale;
    bit got4;
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [9:0]  exp4;

    rst_n = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b0;
    in_valid4 = 1'b0; dividend4 = '0; divisor4 = '0; out_ready4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset_outputs", {13'd0, out_valid, div_zero, ovf, quotient, remainder}, 32'd0);
    check_eq("reset_in_ready", {31'd0, in_ready}, 32'd1);

    directed(16'd1000, 8'd7,    9, {2'b00, 8'd142, 8'd6},  "div1000_7");
    directed(16'hFE01, 8'hFF,   9, {2'b00, 8'hFF,  8'h00}, "max_quot");
    directed(16'h00FF, 8'h01,   9, {2'b00, 8'hFF,  8'h00}, "div_by_1");
    directed(16'h1234, 8'h00,   1, {2'b10, 8'hFF,  8'h34}, "div_zero");
    directed(16'h0A00, 8'h0A,   1, {2'b01, 8'hFF,  8'hFF}, "overflow");

    // Backpressure with a pending new request held throughout.
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(16'd500, 8'd3);
    dividend = 16'd1000; divisor = 8'd7; in_valid = 1'b1;
    wait_out(lat);
    check_eq("bp_lat", 32'(lat), 32'd9);
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_hold", {14'd0, out_valid, in_ready, quotient, remainder},
               {14'd0, 1'b1, 1'b0, 8'd166, 8'd2});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check_eq("bp_ready_after", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
    check_eq("bp_next_lat", 32'(lat), 32'd9);
    check_eq("bp_next_res", {14'd0, div_zero, ovf, quotient, remainder}, {14'd0, 2'b00, 8'd142, 8'd6});

    // Reset in the middle of a computation.
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(16'd1000, 8'd7);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_outputs", {13'd0, out_valid, div_zero, ovf, quotient, remainder}, 32'd0);
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    stale = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check_eq("midrst_no_stale", {31'd0, stale}, 32'd0);
    directed(16'd1000, 8'd7, 9, {2'b00, 8'd142, 8'd6}, "after_rst");

    // Random regression, WIDTH=8, with consumer stalls.
    @(posedge clk);
    #1 stall_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      dd = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       dv = 8'd0;
        1, 2:    dv = 8'($urandom);
        default: begin
          dv = 8'($urandom_range(1, 255));
          dd[15:8] = 8'($urandom_range(0, int'(dv) - 1));
        end
      endcase
      issue(dd, dv);
    end
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    stall_en = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Random regression, WIDTH=4.
    for (int i = 0; i < 1000; i++) begin
      dividend4 = 8'($urandom);
      divisor4  = 4'($urandom);
      if ($urandom_range(0, 2) != 0 && divisor4 != 4'd0)
        dividend4[7:4] = 4'($urandom_range(0, int'(divisor4) - 1));
      exp4 = model4(dividend4, divisor4);
      in_valid4  = 1'b1;
      out_ready4 = 1'b0;
      got4 = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (in_ready4) begin
          got4 = 1'b1;
          break;
        end
      end
      check_eq("w4_accept", 32'(got4), 32'd1);
      @(posedge clk);
      #1 in_valid4 = 1'b0;
      got4 = 1'b0;
      for (int k = 0; k < 60; k++) begin
        out_ready4 = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (out_valid4 && out_ready4) begin
          got4 = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
      end
      check_eq("w4_done", 32'(got4), 32'd1);
      check_eq("w4_result", {22'd0, div_zero4, ovf4, quotient4, remainder4}, {22'd0, exp4});
      $display("w4 op %0d: %02h/%0h q=%0h r=%0h dz=%0b ovf=%0b", i, dividend4, divisor4,
               quotient4, remainder4, div_zero4, ovf4);
      @(posedge clk);
      #1 out_ready4 = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
